mat_mult_stream: RTL and testbench
==================================

// Module: mat_mult_stream
// PURPOSE
// - AXI-Stream matrix multiplier. Receives two NxN unsigned 8-bit matrices A, B as one byte stream.
// - Computes C = A*B and streams C out with TLAST on the final element.
// - Sits between a byte-wide AXIS producer and consumer, one matrix pair per transaction.
// PARAMETERS
// - N   2   matrix dimension (N>=2); input frame = 2*N*N bytes, output frame = N*N bytes
// PORTS
// - axis_clk      in   1  single clock, all logic on rising edge
// - axis_rst_n    in   1  reset, synchronous, active-high (1 = reset)
// - S_AXIS_MATS   in   8  input data: A row-major, then B row-major
// - S_AXIS_VALID  in   1  input data valid
// - S_AXIS_READY  out  1  block can accept input
// - M_AXIS_RES    out  8  result element, C row-major
// - M_AXIS_VALID  out  1  result valid
// - M_AXIS_LAST   out  1  high with the final element C[N-1][N-1]
// - M_AXIS_READY  in   1  downstream can accept
// BEHAVIOUR
// - All outputs are registered. While reset is 1 at a clock edge: state=LOAD, counters=0,
//   S_AXIS_READY=0, M_AXIS_VALID=0, M_AXIS_LAST=0, M_AXIS_RES=0, A/B/C buffers cleared.
// - First cycle after reset released: S_AXIS_READY=1.
// - Reset asserted mid-operation aborts the frame; partial data is discarded; no output is produced for it.
// - FSM LOAD -> COMPUTE -> OUTPUT -> LOAD. No overlap: input is stalled in COMPUTE/OUTPUT.
// - LOAD: S_AXIS_READY=1. A byte is taken only on an edge with S_AXIS_VALID&&S_AXIS_READY.
//   - Bytes 0..N*N-1 go to A[i][j] (idx=i*N+j). Bytes N*N..2N*N-1 go to B.
//   - VALID low inserts wait cycles with no effect.
//   - On the handshake of byte 2*N*N-1: S_AXIS_READY falls the next cycle and state=COMPUTE.
// - COMPUTE: one multiply-accumulate per cycle, N^3 cycles, order i,j outer and k inner.
//   - acc = sum over k of A[i][k]*B[k][j], computed with 8-bit products/sums.
//   - C[i][j] = acc mod 256 (unsigned, wrap-around, no saturation).
//   - After the N^3-th cycle, state=OUTPUT.
// - OUTPUT: M_AXIS_VALID=1 from the first OUTPUT cycle; M_AXIS_RES=C[0][0].
//   - For N=2, VALID asserts 9 cycles after the last input handshake edge.
//   - On each edge with VALID&&READY, advance to the next element row-major.
//   - RES/VALID/LAST hold stable while READY=0.
//   - M_AXIS_LAST=1 only while presenting element N*N-1.
//   - On its handshake: VALID=0, LAST=0, state=LOAD, S_AXIS_READY=1 the next cycle.
// - S_AXIS_READY and M_AXIS_VALID are never high in the same cycle.
// - Back-to-back frames are fully independent; buffers are overwritten.
// TESTING
// - Reset 2 cycles, VALID=0 -> READY=0 in reset, 1 after; M_AXIS_VALID, LAST, RES all 0.
// - N=2, A=[1,2;3,4], B=[5,6;7,8], READY=1 -> out 19,22,43,50; LAST only on 50; 4 beats.
// - Continuous 0x10,0x20,0x30 cycling stream -> A=[10,20;30,10], B=[20,30;10,20] hex.
//   - Every product wraps -> out 0,0,0,0; next frame starts at 0x30 and is accepted after LAST.
// - A=[16,16;1,1], B=[16,1;16,1] -> out 0,32,32,2; checks mod-256 wrap.
// - Toggle M_AXIS_READY 1/0 every cycle -> same 4 values in order; RES/LAST stable while stalled;
//   S_AXIS_READY stays 0 until after LAST handshake.
// - Reset after 5 input bytes, then a full new frame -> only the new frame's result appears,
//   exactly one LAST.

Source files
------------

// File: rtl/mat_mult_stream_if.sv
// Byte-wide AXI-Stream pair for the matrix multiplier: operand stream in, result stream out.
// Signal names are kept from the original port list so existing wiring maps one-to-one.
interface mat_mult_stream_if;
  logic [7:0] S_AXIS_MATS;
  logic       S_AXIS_VALID;
  logic       S_AXIS_READY;
  logic [7:0] M_AXIS_RES;
  logic       M_AXIS_VALID;
  logic       M_AXIS_LAST;
  logic       M_AXIS_READY;

  // The multiplier block itself: sinks operands, sources results.
  modport slave (
    input  S_AXIS_MATS, S_AXIS_VALID, M_AXIS_READY,
    output S_AXIS_READY, M_AXIS_RES, M_AXIS_VALID, M_AXIS_LAST
  );

  // Surrounding producer/consumer.
  modport master (
    output S_AXIS_MATS, S_AXIS_VALID, M_AXIS_READY,
    input  S_AXIS_READY, M_AXIS_RES, M_AXIS_VALID, M_AXIS_LAST
  );
endinterface

// File: rtl/mat_mult_stream.sv
// Streaming NxN unsigned 8-bit matrix multiplier: loads A then B, computes C=A*B mod 256,
// then streams C row-major with LAST on the final element.
module mat_mult_stream #(
  parameter int unsigned N = 2
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  mat_mult_stream_if.slave axis
);
  localparam int unsigned NN = N * N;
  localparam int unsigned N3 = N * N * N;
  localparam int unsigned CW = $clog2(2 * NN + N3 + 1);
  localparam int unsigned EW = $clog2(NN);
  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUTPUT} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;

  logic            r_s_ready;
  logic            r_m_valid;
  logic            r_m_last;
  logic [7:0]      r_m_res;

  logic [7:0]      r_a [NN];
  logic [7:0]      r_b [NN];
  logic [7:0]      r_c [NN];

  logic [IW-1:0]   r_i, r_j, r_k;
  logic [7:0]      r_prod, r_acc;
  logic            r_pv, r_pfirst, r_plast;
  logic [EW-1:0]   r_pidx;

  logic            w_s_hs, w_m_hs, w_issue;
  logic [EW-1:0]   w_aidx, w_bidx, w_cidx, w_bload;
  logic [7:0]      w_prod, w_sum;

  assign w_s_hs  = axis.S_AXIS_VALID && r_s_ready;
  assign w_m_hs  = r_m_valid && axis.M_AXIS_READY;
  assign w_issue = (r_state == ST_COMPUTE) && (r_cnt < CW'(N3));

  assign w_aidx  = EW'(int'(r_i) * N + int'(r_k));
  assign w_bidx  = EW'(int'(r_k) * N + int'(r_j));
  assign w_cidx  = EW'(int'(r_i) * N + int'(r_j));
  assign w_bload = EW'(r_cnt - CW'(NN));

  assign w_prod  = r_a[w_aidx] * r_b[w_bidx];
  assign w_sum   = (r_pfirst ? 8'd0 : r_acc) + r_prod;

  assign axis.S_AXIS_READY = r_s_ready;
  assign axis.M_AXIS_VALID = r_m_valid;
  assign axis.M_AXIS_LAST  = r_m_last;
  assign axis.M_AXIS_RES   = r_m_res;

  // r_cnt is shared: byte index in LOAD, MAC issue count in COMPUTE, element index in OUTPUT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_LOAD: begin
        if (w_s_hs) begin
          if (r_cnt == CW'(2 * NN - 1)) begin
            w_state_nxt = ST_COMPUTE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (r_cnt == CW'(N3)) begin
          w_state_nxt = ST_OUTPUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (w_m_hs) begin
          if (r_cnt == CW'(NN - 1)) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst_n) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stream outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge axis_clk) begin
    if (axis_rst_n) begin
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_res   <= '0;
    end else begin
      r_s_ready <= (w_state_nxt == ST_LOAD);
      r_m_valid <= (w_state_nxt == ST_OUTPUT);
      r_m_last  <= (w_state_nxt == ST_OUTPUT) && (w_cnt_nxt == CW'(NN - 1));
      if (w_state_nxt == ST_OUTPUT)
        r_m_res <= r_c[w_cnt_nxt[EW-1:0]];
    end
  end

  // Products are registered before accumulation, so COMPUTE ends with one drain cycle
  // after the last of the N^3 issues.
  always_ff @(posedge axis_clk) begin
    if (axis_rst_n) begin
      for (int unsigned idx = 0; idx < NN; idx++) begin
        r_a[idx] <= '0;
        r_b[idx] <= '0;
        r_c[idx] <= '0;
      end
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
      r_pv     <= 1'b0;
      r_pfirst <= 1'b0;
      r_plast  <= 1'b0;
      r_pidx   <= '0;
    end else begin
      if (w_s_hs) begin
        if (r_cnt < CW'(NN))
          r_a[r_cnt[EW-1:0]] <= axis.S_AXIS_MATS;
        else
          r_b[w_bload] <= axis.S_AXIS_MATS;
      end

      r_pv <= w_issue;
      if (w_issue) begin
        r_prod   <= w_prod;
        r_pidx   <= w_cidx;
        r_pfirst <= (r_k == '0);
        r_plast  <= (r_k == IW'(N - 1));
        if (r_k == IW'(N - 1)) begin
          r_k <= '0;
          if (r_j == IW'(N - 1)) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end else if (r_state != ST_COMPUTE) begin
        r_i <= '0;
        r_j <= '0;
        r_k <= '0;
      end

      if (r_pv) begin
        if (r_plast)
          r_c[r_pidx] <= w_sum;
        else
          r_acc <= w_sum;
      end
    end
  end
endmodule

// File: tb/tb_mat_mult_stream.sv
// Directed bench for mat_mult_stream (N=2): reset state, products, mod-256 wrap,
// output back-pressure, back-to-back frames and mid-frame reset.
module tb_mat_mult_stream;
  typedef logic [7:0] frame_t [8];
  typedef logic [7:0] res_t [4];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   hs_cyc = 0;

  mat_mult_stream_if axis ();

  mat_mult_stream #(.N(2)) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst),
    .axis       (axis)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers the first n bytes; optionally leaves VALID high with hold_byte afterwards.
  task automatic send(input frame_t f, input int n, input bit hold, input logic [7:0] hold_byte);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      axis.S_AXIS_MATS  = f[i];
      axis.S_AXIS_VALID = 1'b1;
      while (!axis.S_AXIS_READY && guard < 100) begin
        step();
        guard++;
      end
      chk($sformatf("in_wait[%0d]", i), 32'(guard < 100), 32'd1);
      step();
    end
    hs_cyc = cyc;
    if (hold) begin
      axis.S_AXIS_MATS = hold_byte;
    end else begin
      axis.S_AXIS_VALID = 1'b0;
      axis.S_AXIS_MATS  = 8'h00;
    end
  endtask

  task automatic recv(input res_t exp, input bit toggle);
    int beat, lasts, guard;
    bit rdy;
    beat = 0; lasts = 0; guard = 0; rdy = 1'b1;
    while (beat < 4 && guard < 300) begin
      axis.M_AXIS_READY = toggle ? rdy : 1'b1;
      if (axis.M_AXIS_VALID) begin
        chk($sformatf("res[%0d]", beat), 32'(axis.M_AXIS_RES), 32'(exp[beat]));
        chk($sformatf("last[%0d]", beat), 32'(axis.M_AXIS_LAST), 32'(beat == 3));
        chk($sformatf("s_ready_out[%0d]", beat), 32'(axis.S_AXIS_READY), 32'd0);
        if (axis.M_AXIS_READY) begin
          if (axis.M_AXIS_LAST) lasts++;
          beat++;
        end
      end
      step();
      guard++;
      rdy = ~rdy;
    end
    chk("beats", 32'(beat), 32'd4);
    chk("last_count", 32'(lasts), 32'd1);
    chk("valid_after", 32'(axis.M_AXIS_VALID), 32'd0);
    chk("last_after", 32'(axis.M_AXIS_LAST), 32'd0);
    chk("s_ready_after", 32'(axis.S_AXIS_READY), 32'd1);
    axis.M_AXIS_READY = 1'b1;
  endtask

  initial begin : main
    frame_t f_basic, f_cyc, f_cyc2, f_wrap, f_diag;
    res_t   r_basic, r_zero, r_wrap, r_diag;
    int     guard, extra;

    f_basic = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    r_basic = '{8'd19, 8'd22, 8'd43, 8'd50};
    f_cyc   = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20};
    f_cyc2  = '{8'h30, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 8'h10};
    r_zero  = '{8'd0, 8'd0, 8'd0, 8'd0};
    f_wrap  = '{8'd16, 8'd16, 8'd1, 8'd1, 8'd16, 8'd1, 8'd16, 8'd1};
    r_wrap  = '{8'd0, 8'd32, 8'd32, 8'd2};
    f_diag  = '{8'd2, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    r_diag  = '{8'd6, 8'd8, 8'd10, 8'd12};

    axis.S_AXIS_MATS  = 8'h00;
    axis.S_AXIS_VALID = 1'b0;
    axis.M_AXIS_READY = 1'b1;

    // Reset for two cycles
    rst = 1'b1;
    step();
    step();
    chk("rst_s_ready", 32'(axis.S_AXIS_READY), 32'd0);
    chk("rst_m_valid", 32'(axis.M_AXIS_VALID), 32'd0);
    chk("rst_m_last", 32'(axis.M_AXIS_LAST), 32'd0);
    chk("rst_m_res", 32'(axis.M_AXIS_RES), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_s_ready", 32'(axis.S_AXIS_READY), 32'd1);

    // Basic product with latency check
    send(f_basic, 8, 1'b0, 8'h00);
    chk("s_ready_fall", 32'(axis.S_AXIS_READY), 32'd0);
    guard = 0;
    while (!axis.M_AXIS_VALID && guard < 50) begin
      step();
      guard++;
    end
    chk("latency", 32'(cyc - hs_cyc), 32'd9);
    recv(r_basic, 1'b0);

    // Continuous cycling stream: every product wraps; next frame starts with 0x30
    send(f_cyc, 8, 1'b1, 8'h30);
    chk("cyc_s_ready_fall", 32'(axis.S_AXIS_READY), 32'd0);
    recv(r_zero, 1'b0);
    send(f_cyc2, 8, 1'b0, 8'h00);
    recv(r_zero, 1'b0);

    // Mod-256 wrap of sums
    send(f_wrap, 8, 1'b0, 8'h00);
    recv(r_wrap, 1'b0);

    // Downstream back-pressure toggling every cycle
    send(f_basic, 8, 1'b0, 8'h00);
    recv(r_basic, 1'b1);

    // Reset mid-frame, then a fresh frame
    send(f_wrap, 5, 1'b0, 8'h00);
    rst = 1'b1;
    step();
    step();
    chk("mid_rst_s_ready", 32'(axis.S_AXIS_READY), 32'd0);
    chk("mid_rst_m_valid", 32'(axis.M_AXIS_VALID), 32'd0);
    rst = 1'b0;
    step();
    chk("mid_post_rst_s_ready", 32'(axis.S_AXIS_READY), 32'd1);
    send(f_diag, 8, 1'b0, 8'h00);
    recv(r_diag, 1'b0);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      if (axis.M_AXIS_VALID) extra++;
      step();
    end
    chk("no_extra_output", 32'(extra), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
